// File: rtl/qdec_pkg.sv
// -----------------------------------------------------------------------------
// qdec_pkg
// Shared types and helpers for the quadrature decoder.
//   qdec_state_e : accepted {A,B} level, one state per Gray-code position
//   qdec_move_e  : classification of a change between two accepted levels
//   qdec_fwd_next: successor of a level in the forward direction
//   qdec_classify: maps {prev, cur} to a qdec_move_e
// Forward rotation is 10 -> 11 -> 01 -> 00 -> 10; reverse is the opposite.
// -----------------------------------------------------------------------------
package qdec_pkg;

  typedef enum logic [1:0] {
    QDEC_S00 = 2'b00,
    QDEC_S01 = 2'b01,
    QDEC_S10 = 2'b10,
    QDEC_S11 = 2'b11
  } qdec_state_e;

  typedef enum logic [1:0] {
    QDEC_NONE = 2'd0,
    QDEC_FWD  = 2'd1,
    QDEC_REV  = 2'd2,
    QDEC_ERR  = 2'd3
  } qdec_move_e;

  function automatic qdec_state_e qdec_fwd_next(input qdec_state_e s);
    case (s)
      QDEC_S10: return QDEC_S11;
      QDEC_S11: return QDEC_S01;
      QDEC_S01: return QDEC_S00;
      default:  return QDEC_S10;
    endcase
  endfunction

  function automatic qdec_move_e qdec_classify(input qdec_state_e prev,
                                               input qdec_state_e cur);
    if (prev == cur) begin
      return QDEC_NONE;
    end else if (qdec_fwd_next(prev) == cur) begin
      return QDEC_FWD;
    end else if (qdec_fwd_next(cur) == prev) begin
      return QDEC_REV;
    end else begin
      return QDEC_ERR;
    end
  endfunction

endpackage

// File: rtl/qdec_filter.sv
// -----------------------------------------------------------------------------
// qdec_filter
// Two-flop synchronizer on the raw {A,B} lines followed by a glitch filter.
// A new level is accepted once the synchronized value has matched the held
// candidate for FILTER_LEN consecutive clocks.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   ab_in    : raw {A,B}, asynchronous to clk
//   ab_acc   : accepted level, meaningful while ab_stb is high
//   ab_stb   : one-cycle strobe, a level is accepted this cycle
// -----------------------------------------------------------------------------
module qdec_filter #(
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] ab_in,
  output logic [1:0] ab_acc,
  output logic       ab_stb
);

  localparam logic [3:0] CNT_LAST = 4'(FILTER_LEN - 1);
  localparam logic [3:0] CNT_FULL = 4'(FILTER_LEN);

  logic [1:0] sync1_q, sync1_d;
  logic [1:0] sync2_q, sync2_d;
  logic [1:0] cand_q, cand_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] fill_q, fill_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cand_q  <= '0;
      cnt_q   <= '0;
      fill_q  <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
    end
  end

  // The strobe is combinational so the decoder's output register is the only
  // stage after the filter: a change reaches the outputs FILTER_LEN+3 edges
  // after it is first sampled.
  always_comb begin
    sync1_d = ab_in;
    sync2_d = sync1_q;
    fill_d  = {fill_q[0], 1'b1};
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    ab_stb  = 1'b0;
    // Until the synchronizer holds a post-reset sample, its reset zeros must
    // not be mistaken for a stable 00 level (matters for short filters).
    if (!fill_q[1] || (sync2_q != cand_q)) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else begin
      if (cnt_q == CNT_LAST) begin
        ab_stb = 1'b1;
      end
      if (cnt_q != CNT_FULL) begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  assign ab_acc = cand_q;

endmodule

// File: rtl/quadrature_decoder.sv
// -----------------------------------------------------------------------------
// quadrature_decoder
// Decodes filtered quadrature A/B levels into a signed position count and
// flags illegal two-bit jumps.
// Ports:
//   CLOCK, RESET : clock, asynchronous active-high reset
//   A, B         : encoder channels, asynchronous to CLOCK
//   CLEAR        : synchronous one-cycle position clear
//   position     : two's complement position, wraps
//   step         : one-cycle pulse per legal transition
//   direction    : 1 = last step forward, 0 = reverse
//   error        : one-cycle pulse per illegal transition
//   err_count    : saturating count of illegal transitions
//   velocity     : signed steps per VEL_PERIOD window
// Build option: define QDEC_VELOCITY_EN to include the velocity window;
// otherwise velocity reads 0.
// -----------------------------------------------------------------------------
module quadrature_decoder
  import qdec_pkg::*;
#(
  parameter int unsigned COUNTER_BITS = 32,
  parameter int unsigned FILTER_LEN   = 3,
  parameter int unsigned ERR_BITS     = 8,
  parameter int unsigned VEL_PERIOD   = 50000
) (
  input  logic                    CLOCK,
  input  logic                    RESET,
  input  logic                    A,
  input  logic                    B,
  input  logic                    CLEAR,
  output logic [COUNTER_BITS-1:0] position,
  output logic                    step,
  output logic                    direction,
  output logic                    error,
  output logic [ERR_BITS-1:0]     err_count,
  output logic [COUNTER_BITS-1:0] velocity
);

  if (FILTER_LEN < 1 || FILTER_LEN > 15 || VEL_PERIOD < 1) begin : g_bad_cfg
    $error("quadrature_decoder: FILTER_LEN must be 1..15 and VEL_PERIOD >= 1");
  end

  logic [1:0] ab_acc;
  logic       ab_stb;

  qdec_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_filter (
    .clk   (CLOCK),
    .rst   (RESET),
    .ab_in ({A, B}),
    .ab_acc(ab_acc),
    .ab_stb(ab_stb)
  );

  // ---------------------------------------------------------------------------
  // Decoder FSM: state is the last accepted level.
  // ---------------------------------------------------------------------------
  qdec_state_e state_q, state_d;
  logic        init_q, init_d;
  qdec_move_e  move;

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q <= QDEC_S00;
      init_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      init_q  <= init_d;
    end
  end

  always_comb begin
    state_d = state_q;
    init_d  = init_q;
    if (ab_stb) begin
      state_d = qdec_state_e'(ab_acc);
      init_d  = 1'b0;
    end
  end

  // The first accepted level after reset only seeds the state.
  always_comb begin
    move = QDEC_NONE;
    if (ab_stb && !init_q) begin
      move = qdec_classify(state_q, qdec_state_e'(ab_acc));
    end
  end

  // ---------------------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------------------
  logic [COUNTER_BITS-1:0] position_q, position_d;
  logic                    step_q, step_d;
  logic                    direction_q, direction_d;
  logic                    error_q, error_d;
  logic [ERR_BITS-1:0]     err_count_q, err_count_d;

  always_comb begin
    position_d  = position_q;
    step_d      = 1'b0;
    direction_d = direction_q;
    error_d     = 1'b0;
    err_count_d = err_count_q;
    case (move)
      QDEC_FWD: begin
        position_d  = position_q + COUNTER_BITS'(1);
        direction_d = 1'b1;
        step_d      = 1'b1;
      end
      QDEC_REV: begin
        position_d  = position_q - COUNTER_BITS'(1);
        direction_d = 1'b0;
        step_d      = 1'b1;
      end
      QDEC_ERR: begin
        error_d = 1'b1;
        if (err_count_q != '1) begin
          err_count_d = err_count_q + ERR_BITS'(1);
        end
      end
      default: ;
    endcase
    // Clear overrides the count but step/direction still report the move.
    if (CLEAR) begin
      position_d = '0;
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      position_q  <= '0;
      step_q      <= 1'b0;
      direction_q <= 1'b0;
      error_q     <= 1'b0;
      err_count_q <= '0;
    end else begin
      position_q  <= position_d;
      step_q      <= step_d;
      direction_q <= direction_d;
      error_q     <= error_d;
      err_count_q <= err_count_d;
    end
  end

  assign position  = position_q;
  assign step      = step_q;
  assign direction = direction_q;
  assign error     = error_q;
  assign err_count = err_count_q;

  // ---------------------------------------------------------------------------
  // Velocity window
  // ---------------------------------------------------------------------------
`ifdef QDEC_VELOCITY_EN
  localparam int unsigned WIN_W = (VEL_PERIOD > 1) ? $clog2(VEL_PERIOD) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(VEL_PERIOD - 1);

  logic [WIN_W-1:0]        win_q, win_d;
  logic [COUNTER_BITS-1:0] vacc_q, vacc_d;
  logic [COUNTER_BITS-1:0] velocity_q, velocity_d;
  logic [COUNTER_BITS-1:0] vstep;

  always_comb begin
    vstep = '0;
    if (move == QDEC_FWD) begin
      vstep = COUNTER_BITS'(1);
    end else if (move == QDEC_REV) begin
      vstep = '1;
    end
  end

  // The step landing on the last window cycle belongs to the closing window.
  always_comb begin
    win_d      = win_q + WIN_W'(1);
    vacc_d     = vacc_q + vstep;
    velocity_d = velocity_q;
    if (win_q == WIN_LAST) begin
      win_d      = '0;
      vacc_d     = '0;
      velocity_d = vacc_q + vstep;
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      win_q      <= '0;
      vacc_q     <= '0;
      velocity_q <= '0;
    end else begin
      win_q      <= win_d;
      vacc_q     <= vacc_d;
      velocity_q <= velocity_d;
    end
  end

  assign velocity = velocity_q;
`else
  assign velocity = '0;
`endif

endmodule

// File: tb/tb_quadrature_decoder.sv
module tb_quadrature_decoder;
  localparam int unsigned CB = 32;
  localparam int unsigned FL = 3;
  localparam int unsigned EB = 8;
  localparam int unsigned VP = 100;

  logic          CLOCK = 1'b0;
  logic          RESET;
  logic          A, B, CLEAR;
  logic [CB-1:0] position;
  logic          step, direction, error;
  logic [EB-1:0] err_count;
  logic [CB-1:0] velocity;

  quadrature_decoder #(
    .COUNTER_BITS(CB),
    .FILTER_LEN  (FL),
    .ERR_BITS    (EB),
    .VEL_PERIOD  (VP)
  ) dut (
    .CLOCK    (CLOCK),
    .RESET    (RESET),
    .A        (A),
    .B        (B),
    .CLEAR    (CLEAR),
    .position (position),
    .step     (step),
    .direction(direction),
    .error    (error),
    .err_count(err_count),
    .velocity (velocity)
  );

  always #5 CLOCK = ~CLOCK;

  int n_pass  = 0;
  int n_total = 0;
  int n_steps = 0;
  int n_errs  = 0;

  typedef struct {
    logic [1:0]  ab;
    logic        clr;
    logic [31:0] pos;
    logic        dir;
    int          steps;
    int          errs;
    logic [7:0]  ec;
  } vec_t;

  vec_t vecs[19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Each cycle: active edge, then sample outputs on the falling edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLOCK);
      @(negedge CLOCK);
      if (step === 1'b1) n_steps++;
      if (error === 1'b1) n_errs++;
    end
  endtask

  task automatic set_ab(input logic [1:0] ab);
    {A, B} = ab;
  endtask

  initial begin
    int lat;
    int exp_vel;
    logic [1:0] ab_e;

    //            ab     clr   pos            dir  st er ec
    vecs[0]  = '{2'b10, 1'b0, 32'h0000_0000, 1'b0, 0, 0, 8'd0};
    vecs[1]  = '{2'b11, 1'b0, 32'h0000_0001, 1'b1, 1, 0, 8'd0};
    vecs[2]  = '{2'b01, 1'b0, 32'h0000_0002, 1'b1, 1, 0, 8'd0};
    vecs[3]  = '{2'b00, 1'b0, 32'h0000_0003, 1'b1, 1, 0, 8'd0};
    vecs[4]  = '{2'b10, 1'b0, 32'h0000_0004, 1'b1, 1, 0, 8'd0};
    vecs[5]  = '{2'b11, 1'b0, 32'h0000_0005, 1'b1, 1, 0, 8'd0};
    vecs[6]  = '{2'b01, 1'b0, 32'h0000_0006, 1'b1, 1, 0, 8'd0};
    vecs[7]  = '{2'b00, 1'b0, 32'h0000_0007, 1'b1, 1, 0, 8'd0};
    vecs[8]  = '{2'b10, 1'b0, 32'h0000_0008, 1'b1, 1, 0, 8'd0};
    vecs[9]  = '{2'b10, 1'b1, 32'h0000_0000, 1'b1, 0, 0, 8'd0};
    vecs[10] = '{2'b00, 1'b0, 32'hFFFF_FFFF, 1'b0, 1, 0, 8'd0};
    vecs[11] = '{2'b01, 1'b0, 32'hFFFF_FFFE, 1'b0, 1, 0, 8'd0};
    vecs[12] = '{2'b11, 1'b0, 32'hFFFF_FFFD, 1'b0, 1, 0, 8'd0};
    vecs[13] = '{2'b01, 1'b0, 32'hFFFF_FFFE, 1'b1, 1, 0, 8'd0};
    vecs[14] = '{2'b00, 1'b0, 32'hFFFF_FFFF, 1'b1, 1, 0, 8'd0};
    vecs[15] = '{2'b10, 1'b0, 32'h0000_0000, 1'b1, 1, 0, 8'd0};
    vecs[16] = '{2'b01, 1'b0, 32'h0000_0000, 1'b1, 0, 1, 8'd1};
    vecs[17] = '{2'b10, 1'b0, 32'h0000_0000, 1'b1, 0, 1, 8'd2};
    vecs[18] = '{2'b11, 1'b0, 32'h0000_0001, 1'b1, 1, 0, 8'd2};

    // Reset state
    RESET = 1'b1;
    CLEAR = 1'b0;
    set_ab(2'b10);
    repeat (3) @(negedge CLOCK);
    check("rst position", position, 32'h0);
    check("rst step", {31'b0, step}, 32'h0);
    check("rst direction", {31'b0, direction}, 32'h0);
    check("rst error", {31'b0, error}, 32'h0);
    check("rst err_count", {24'b0, err_count}, 32'h0);
    check("rst velocity", velocity, 32'h0);
    RESET = 1'b0;

    // Table-driven transitions, each held 10 clocks
    foreach (vecs[i]) begin
      n_steps = 0;
      n_errs  = 0;
      set_ab(vecs[i].ab);
      CLEAR = vecs[i].clr;
      tick(1);
      CLEAR = 1'b0;
      tick(9);
      check($sformatf("v%0d position", i), position, vecs[i].pos);
      check($sformatf("v%0d direction", i), {31'b0, direction}, {31'b0, vecs[i].dir});
      check($sformatf("v%0d steps", i), n_steps, vecs[i].steps);
      check($sformatf("v%0d errors", i), n_errs, vecs[i].errs);
      check($sformatf("v%0d err_count", i), {24'b0, err_count}, {24'b0, vecs[i].ec});
    end

    // Latency: 11 -> 01, step must appear after exactly FL+3 edges
    lat = 0;
    n_steps = 0;
    set_ab(2'b01);
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      if (n_steps != 0 && lat == 0) lat = k;
    end
    check("latency edges", lat, FL + 3);
    check("latency steps", n_steps, 1);
    check("latency position", position, 32'h2);

    set_ab(2'b00);
    tick(10);
    set_ab(2'b10);
    tick(10);
    check("pre-glitch position", position, 32'h4);

    // Glitch shorter than the filter
    n_steps = 0;
    n_errs  = 0;
    set_ab(2'b00);
    tick(2);
    set_ab(2'b10);
    tick(12);
    check("glitch steps", n_steps, 0);
    check("glitch errors", n_errs, 0);
    check("glitch position", position, 32'h4);

    set_ab(2'b11);
    tick(10);
    check("pre-clear position", position, 32'h5);

    // CLEAR coincident with an accepted forward step (11 -> 01)
    set_ab(2'b01);
    tick(5);
    CLEAR = 1'b1;
    tick(1);
    CLEAR = 1'b0;
    check("clear+step step", {31'b0, step}, 32'h1);
    check("clear+step position", position, 32'h0);
    check("clear+step direction", {31'b0, direction}, 32'h1);
    tick(4);
    check("post-clear position", position, 32'h0);

    // 300 forced errors, alternating 10 <-> 01
    n_errs  = 0;
    n_steps = 0;
    for (int i = 0; i < 300; i++) begin
      ab_e = (i % 2 == 0) ? 2'b10 : 2'b01;
      set_ab(ab_e);
      tick(6);
    end
    tick(4);
    check("sat error pulses", n_errs, 300);
    check("sat steps", n_steps, 0);
    check("sat err_count", {24'b0, err_count}, 32'hFF);
    check("sat position", position, 32'h0);

    // Mid-operation reset, then init rule and velocity window
    set_ab(2'b01);
    RESET = 1'b1;
    #1;
    check("midrst err_count", {24'b0, err_count}, 32'h0);
    check("midrst direction", {31'b0, direction}, 32'h0);
    @(negedge CLOCK);
    RESET = 1'b0;
    n_steps = 0;
    n_errs  = 0;
    tick(10);
    check("init steps", n_steps, 0);
    check("init errors", n_errs, 0);
    check("init position", position, 32'h0);
    for (int i = 0; i < 10; i++) begin
      case (i % 4)
        0: ab_e = 2'b00;
        1: ab_e = 2'b10;
        2: ab_e = 2'b11;
        default: ab_e = 2'b01;
      endcase
      set_ab(ab_e);
      tick(8);
    end
    tick(9);
    check("vel before window end", velocity, 32'h0);
    tick(1);
`ifdef QDEC_VELOCITY_EN
    exp_vel = 10;
`else
    exp_vel = 0;
`endif
    check("vel at window end", velocity, exp_vel);
    check("vel steps", n_steps, 10);
    check("vel position", position, 32'd10);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/quadrature_decoder.md
Name: quadrature_decoder

Overview:
Receive side of the quadrature encoder interface that the motor simulator drives: samples asynchronous A/B encoder lines, filters glitches and decodes Gray-code transitions into a signed position count.
Sits between the encoder pins (real or simulated motor) and the PID controller, which reads position as its feedback input.
Also flags illegal transitions (two-bit jumps), which indicate overspeed or noise.

Parameters:
COUNTER_BITS, 32, width of the position counter (wraps modulo 2^COUNTER_BITS)
FILTER_LEN, 3, consecutive stable clocks required to accept a new A/B value; legal range 1..15
ERR_BITS, 8, width of the saturating error counter
VEL_PERIOD, 50000, velocity window length in clocks; used only with QDEC_VELOCITY_EN

Ports:
CLOCK  in  1  system clock
RESET  in  1  asynchronous, active-high reset
A  in  1  encoder channel A, asynchronous to CLOCK
B  in  1  encoder channel B, asynchronous to CLOCK
CLEAR  in  1  synchronous position clear, one-cycle strobe
position  out  COUNTER_BITS  decoded position, two's complement
step  out  1  one-cycle pulse on each accepted legal transition
direction  out  1  1 = forward (last step incremented), 0 = reverse
error  out  1  one-cycle pulse on an illegal two-bit transition
err_count  out  ERR_BITS  saturating count of illegal transitions
velocity  out  COUNTER_BITS  signed steps per window; reads 0 when the feature is compiled out

Behaviour:
- Interface: one clock, CLOCK; reset RESET is asynchronous and active-high.
- Reset values:
  - position=0, step=0, direction=0, error=0, err_count=0, velocity=0.
  - Synchronizer flops=0, filter counter=0.
  - init flag=1.
- Input path:
  - 2-flop synchronizer on {A,B}.
  - Glitch filter holds a candidate value. If the synced value differs from the candidate, the candidate is reloaded and the counter cleared.
  - When the synced value has equalled the candidate for FILTER_LEN consecutive clocks, the candidate becomes the accepted value.
- Decoder FSM, states by accepted {A,B}:
  - Forward sequence is 10 -> 11 -> 01 -> 00 -> 10; reverse is the opposite order.
  - Forward step: position+1, direction=1, step pulses.
  - Reverse step: position-1, direction=0, step pulses.
  - Same value: no action.
  - Two-bit change (10<->01, 11<->00): position unchanged, direction unchanged, error pulses, err_count+1 saturating at all-ones. The accepted state still moves to the new value.
- First value after reset: the first accepted value only loads the state (init flag cleared). No step, no error.
- Latency: the input changes and then stays stable. position/step/error update on the (FILTER_LEN+3)th rising edge after the first edge that samples the new level: 2 sync + FILTER_LEN filter + 1 output register.
- Wrap-around: modulo 2^COUNTER_BITS, no saturation. From 0, a reverse step gives all-ones; from the max positive value, a forward step gives the min negative value.
- CLEAR:
  - Next cycle position=0.
  - If coincident with a step, clear wins (position=0), but step/direction still report the transition.
  - CLEAR does not affect err_count or FSM state.
- RESET mid-operation: all state returns to reset values immediately. Decoding restarts via the init-flag rule.
- Max input rate is one transition per FILTER_LEN+1 clocks. Faster input either drops edges or produces two-bit jumps, which are reported via error.

Optional Feature:
QDEC_VELOCITY_EN:
- Defined:
  - A free-running window counter counts 0..VEL_PERIOD-1.
  - A signed accumulator adds +1 or -1 per step.
  - At window end, velocity takes the accumulator value including that cycle's step, and the accumulator restarts from 0.
  - CLEAR does not affect velocity.
- Undefined: no window logic; velocity is tied to 0.

Decomposition:
- Package qdec_pkg:
  - 2-bit state constants QDEC_S10, QDEC_S11, QDEC_S01, QDEC_S00.
  - Transition classification enum {QDEC_NONE, QDEC_FWD, QDEC_REV, QDEC_ERR}.
  - A function mapping {prev, cur} to that classification.
- Sub-module qdec_filter: 2-bit synchronizer plus FILTER_LEN glitch filter, with the accepted value and a "new accepted" strobe as outputs. Instantiated once.

Test Plan:
- Reset, then AB=10 held 10 clocks -> no step, position=0. Then 8 forward transitions, each held 8 clocks -> position=8, direction=1, 8 step pulses.
- From position 0, 3 reverse transitions -> position=0xFFFFFFFD, direction=0; step pulse lands exactly FILTER_LEN+3 edges after the input change.
- AB glitch 10->00->10 with 00 lasting 2 clocks (FILTER_LEN=3) -> no step, no error, position unchanged.
- Jump 10->01 held stable -> one error pulse, err_count=1, position unchanged. Then 300 forced errors -> err_count saturates at 255.
- CLEAR asserted the same cycle a forward step is accepted, with position=5 -> position=0, step=1.
- With QDEC_VELOCITY_EN, VEL_PERIOD=100: 10 forward steps inside one window -> velocity=10 at the window boundary. Without the macro, velocity stays 0.
